// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read/write ports and the
// RV32M multiply/divide unit. The core side drives the request; the unit
// returns busy, the write strobe, the result and the destination index.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, A, B, rd_in,
    input  busy, done, Result, rd_out
  );

  modport slave (
    input  start, funct3, A, B, rd_in,
    output busy, done, Result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, a 32-step shift-add multiply or restoring divide runs in CALC, and
// FIX applies the sign correction and picks the architectural result.
// Divide-by-zero and signed-overflow cases bypass the loop entirely.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_in;
  logic              sign_a_q, sign_b_q;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [XLEN-1:0]   opr_q;
  // Multiply: {partial product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [CW-1:0]     count_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  // Request-side decode (valid while IDLE with start high).
  logic              in_sign_a, in_sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, overflow, special_in;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   opr_in;
  logic [2*XLEN-1:0] acc_in;

  // Iteration and fix-up datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fix_val;

  // Decode the incoming request: sign flags, magnitudes and bypass cases.
  always_comb begin
    op_in       = op_e'(bus.funct3);
    in_sign_a   = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.A[XLEN-1];
    in_sign_b   = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.B[XLEN-1];
    mag_a       = in_sign_a ? -bus.A : bus.A;
    mag_b       = in_sign_b ? -bus.B : bus.B;
    b_zero      = (bus.B == '0);
    overflow    = (op_in inside {OP_DIV, OP_REM}) &&
                  (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1);
    special_in  = bus.funct3[2] && (b_zero || overflow);
    special_val = '0;
    if (b_zero) begin
      special_val = bus.funct3[1] ? bus.A : '1;
    end else if (op_in == OP_DIV) begin
      special_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    // Multiply iterates over B's bits adding A; divide shifts A's bits in against B.
    if (bus.funct3[2]) begin
      opr_in = mag_b;
      acc_in = {{XLEN{1'b0}}, mag_a};
    end else begin
      opr_in = mag_a;
      acc_in = {{XLEN{1'b0}}, mag_b};
    end
  end

  // One loop step plus the sign fix-up applied in FIX.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first); a missed branch would otherwise infer a latch.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opr_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opr_q});
    div_diff  = div_shift[XLEN-1:0] - opr_q;
    if (op_q[2]) begin
      acc_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                      fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = (sign_a_q ^ sign_b_q) ? -quot : quot;
      default:                     fix_val = sign_a_q ? -rem : rem;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = special_in ? S_DONE : S_CALC;
      S_CALC: if (count_q == CW'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, loop iteration and result/destination registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opr_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q     <= op_in;
            rd_q     <= bus.rd_in;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            opr_q    <= opr_in;
            acc_q    <= acc_in;
            count_q  <= '0;
            if (special_in) result_q <= special_val;
          end
        end
        S_CALC: begin
          acc_q   <= acc_next;
          count_q <= count_q + CW'(1);
        end
        S_FIX:   result_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.Result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, a held
// start with operands changing mid-operation, a mid-operation reset, and
// random operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'b000: begin p = ua * ub;            return p[31:0];  end
      3'b001: begin p = sa * sb;            return p[63:32]; end
      3'b010: begin p = sa * longint'(ub);  return p[63:32]; end
      3'b011: begin p = ua * ub;            return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'($urandom_range(1, 15));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and check result, destination, latency, busy and hold.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit hold);
    logic [31:0] exp;
    int          exp_lat;
    int          edges;
    int          busy_cnt;
    bit          seen;
    exp     = ref_result(f, a, b);
    exp_lat = is_special(f, a, b) ? 0 : 33;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.A      = a;
    bus.B      = b;
    bus.rd_in  = rd;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.start  = 1'b0;
      bus.funct3 = 3'($urandom);
      bus.A      = $urandom;
      bus.B      = $urandom;
      bus.rd_in  = 5'($urandom);
    end
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && edges < 100) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (hold) begin
          bus.A = $urandom;
          bus.B = $urandom;
        end
        @(posedge clk);
        #1;
        edges++;
      end
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " result"}, 64'(bus.Result), 64'(exp));
    check({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
    check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse_width"}, 64'(bus.done), 64'd0);
    check({tag, " result_hold"}, 64'(bus.Result), 64'(exp));
    check({tag, " busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  // Watch for stray done pulses over a window of cycles.
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check({tag, " no_done"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.A      = '0;
    bus.B      = '0;
    bus.rd_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.Result), 64'd0);
    check("reset rd_out", 64'(bus.rd_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("idle", 5);

    // Directed corner cases.
    run_op("mul_neg",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3,  1'b0);
    run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  1'b0);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  1'b0);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  1'b0);
    run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  1'b0);
    run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  1'b0);
    run_op("divu",      3'b101, 32'd100,       32'd7,         5'd9,  1'b0);
    run_op("remu",      3'b111, 32'd100,       32'd7,         5'd10, 1'b0);
    run_op("divu_zero", 3'b101, 32'd5,         32'd0,         5'd11, 1'b0);
    run_op("rem_zero",  3'b110, 32'd5,         32'd0,         5'd12, 1'b0);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);

    // start held high with operands changing while the unit is busy.
    run_op("hold_start", 3'b000, 32'd12345, 32'd678, 5'd15, 1'b1);
    expect_quiet("hold_start", 40);

    // Reset when the iteration counter has reached 10.
    run_op("pre_reset", 3'b001, 32'h1234_5678, 32'h8765_4321, 5'd21, 1'b0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.A      = 32'd99;
    bus.B      = 32'd101;
    bus.rd_in  = 5'd17;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset done", 64'(bus.done), 64'd0);
    check("midreset result", 64'(bus.Result), 64'd0);
    check("midreset rd_out", 64'(bus.rd_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("midreset", 40);
    run_op("post_reset", 3'b000, 32'd99, 32'd101, 5'd18, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom), rand_operand(), rand_operand(),
             5'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
